scroll_display_ctrl: RTL and testbench
======================================

// Module: scroll_display_ctrl
// PURPOSE
//  Parametrised scrolling-message driver for a multiplexed common-anode 7-segment bank.
//  Holds a loaded message of MSG_LEN 4-bit symbols and scrolls a NUM_DIGITS-wide window
//    across it circularly, left or right.
//  Dwells HOLD_STEPS steps at position 0 on every revolution, and supports pause.
//  Sits between the switch/BCD front end (Binary_to_BCD) and the board pins.
// PARAMETERS
//  NUM_DIGITS   4           digits in the bank (>=2)
//  MSG_LEN      8           message symbols (>= NUM_DIGITS, elaboration $error otherwise)
//  SCROLL_DIV   50_000_000  clk cycles per scroll step (>=2)
//  REFRESH_DIV  50_000      clk cycles per digit refresh slot (>=1)
//  HOLD_STEPS   3           extra steps dwelt at pos 0 per revolution (0 = no dwell)
// PORTS
//  clk        in   1             system clock
//  reset      in   1             synchronous, active-low reset
//  msg_data   in   4*MSG_LEN     symbol i at [4i+3:4i]; 0-9 digit, A-E hex, F blank
//  load       in   1             1-cycle strobe: capture msg_data, restart scroll
//  dir        in   1             0 = text moves left (pos++), 1 = text moves right (pos--)
//  pause      in   1             1 = freeze scroll/dwell; refresh continues
//  seg        out  7             active-low segments {g,f,e,d,c,b,a}
//  en         out  NUM_DIGITS    active-low digit enables, one-cold; en[NUM_DIGITS-1] = leftmost
//  scroll_pos out  clog2(MSG_LEN) current window start index
//  step       out  1             1-cycle pulse on each executed scroll/dwell step
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - All counters 0 and message buffer all-F.
//   - State IDLE.
//   - seg=7'h7F, en=all ones, scroll_pos=0, step=0.
//  FSM:
//   - IDLE: display stays blank. load -> HOLD.
//   - HOLD: pos=0; counts HOLD_STEPS steps, then -> SCROLL. HOLD_STEPS==0 -> SCROLL directly.
//   - SCROLL: each step moves pos by +-1 mod MSG_LEN.
//       dir=0: wrap MSG_LEN-1 -> 0. dir=1: wrap 0 -> MSG_LEN-1.
//       Landing on pos 0 -> HOLD.
//  Step divider:
//   - Counts 0..SCROLL_DIV-1 in HOLD/SCROLL.
//   - The terminal count produces a step; step pulses and pos/hold counter update on the same edge.
//   - pause=1 freezes the divider and suppresses step. Resuming continues from the frozen count.
//  Load:
//   - Captures msg_data and enters HOLD with pos=0, divider=0 and hold count=0 on the next edge.
//   - Allowed in any state, including mid-scroll.
//   - Wins over a coincident step, which is dropped (step=0).
//  dir is sampled only at a step edge. A change between steps takes effect at the next step.
//  Refresh:
//   - slot counter 0..REFRESH_DIV-1; digit index k counts 0..NUM_DIGITS-1 and wraps.
//   - Runs in every state except reset, and is independent of pause.
//  Display:
//   - Digit k from left shows msg[(pos+k) mod MSG_LEN]; the mod must not use a divider.
//   - seg and en are registered together from k and pos, so they never mismatch by a cycle.
//   - Output latency: 1 clk after k changes.
//   - IDLE forces seg=7'h7F; en still scans.
// STRUCTURE
//  Package scroll_disp_pkg:
//   - SYM_BLANK=4'hF.
//   - typedef scroll_state_t {IDLE, HOLD, SCROLL}.
//   - 7-segment pattern constants.
//  Sub-module hex7seg (4-bit symbol -> active-low seg): combinational, instantiated once.
//  Remainder is a single always_ff for counters/FSM plus a combinational window-index adder.
// TESTING  (NUM_DIGITS=4, MSG_LEN=6, SCROLL_DIV=4, REFRESH_DIV=2, HOLD_STEPS=2)
//  1. Reset: hold reset=0 for 3 clk.
//     -> seg=7F, en=F, scroll_pos=0, step=0. No step while IDLE even with pause=0.
//  2. Load msg 0x543210 (symbol0=0), dir=0.
//     -> 2 steps at pos 0, then pos 1,2,3,4,5,0, one every 4 clk; HOLD repeats.
//     -> At pos 4, left->right digits show 4,5,0,1.
//  3. dir=1 from pos 0 in SCROLL.
//     -> next pos=5 then 4; at pos 5 digits show 5,0,1,2.
//     -> dir toggled mid-divider changes nothing until the step edge.
//  4. pause=1 for 20 clk mid-SCROLL.
//     -> scroll_pos constant, no step pulses, en keeps cycling E,D,B,7 pattern every 2 clk.
//     -> After release, the next step arrives after the remaining divider count.
//  5. load coincident with step at pos 3.
//     -> step=0, pos=0, state HOLD, new message shown on next refresh.
//  6. Reset asserted mid-SCROLL at pos 2.
//     -> next edge seg=7F, en=F, pos=0, IDLE. The old message is not displayed after reset release.

Source files
------------

// File: rtl/scroll_display_ctrl_pkg.sv
// Shared types and 7-segment constants for the scrolling message driver.
package scroll_disp_pkg;

    localparam logic [3:0] SYM_BLANK = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, HOLD, SCROLL} scroll_state_t;

    // Active-low {g,f,e,d,c,b,a}, indexed by symbol; F is blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/scroll_display_ctrl_hex7seg.sv
// Symbol to active-low segment decoder.
module hex7seg
    import scroll_disp_pkg::*;
(
    input  logic [3:0] sym_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[sym_i];

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling-message driver for a multiplexed common-anode 7-segment bank.
module scroll_display_ctrl
    import scroll_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_LEN     = 8,
    parameter int SCROLL_DIV  = 50_000_000,
    parameter int REFRESH_DIV = 50_000,
    parameter int HOLD_STEPS  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [4*MSG_LEN-1:0]       msg_data,
    input  logic                       load,
    input  logic                       dir,
    input  logic                       pause,
    output logic [6:0]                 seg,
    output logic [NUM_DIGITS-1:0]      en,
    output logic [$clog2(MSG_LEN)-1:0] scroll_pos,
    output logic                       step
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int DW = $clog2(SCROLL_DIV);
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int KW = $clog2(NUM_DIGITS);
    localparam int HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam int IW = $clog2(MSG_LEN + NUM_DIGITS) + 1;

    if (MSG_LEN < NUM_DIGITS) begin : g_bad_len
        $error("scroll_display_ctrl: MSG_LEN must be >= NUM_DIGITS");
    end

    scroll_state_t                state_q, state_d;
    logic [MSG_LEN-1:0][3:0]      msg_q, msg_d;
    logic [PW-1:0]                pos_q, pos_d, pos_next;
    logic [DW-1:0]                div_q, div_d;
    logic [HW-1:0]                hold_q, hold_d;
    logic [SW-1:0]                slot_q, slot_d;
    logic [KW-1:0]                k_q, k_d;
    logic [6:0]                   seg_q, seg_d, seg_w;
    logic [NUM_DIGITS-1:0]        en_q, en_d;
    logic                         step_q, step_d;
    logic [IW-1:0]                win_sum;
    logic [PW-1:0]                win_idx;

    // Scan slot k drives en[k], i.e. the digit NUM_DIGITS-1-k from the left.
    always_comb begin
        win_sum = IW'(pos_q) + IW'(NUM_DIGITS - 1) - IW'(k_q);
        win_idx = (win_sum >= IW'(MSG_LEN)) ? PW'(win_sum - IW'(MSG_LEN)) : PW'(win_sum);
    end

    hex7seg u_dec (.sym_i(msg_q[win_idx]), .seg_o(seg_w));

    always_comb begin
        if (dir) pos_next = (pos_q == '0) ? PW'(MSG_LEN - 1) : pos_q - PW'(1);
        else     pos_next = (pos_q == PW'(MSG_LEN - 1)) ? '0 : pos_q + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        pos_d   = pos_q;
        div_d   = div_q;
        hold_d  = hold_q;
        step_d  = 1'b0;
        slot_d  = slot_q + SW'(1);
        k_d     = k_q;
        seg_d   = (state_q == IDLE) ? SEG_BLANK : seg_w;
        en_d    = ~(NUM_DIGITS'(1) << k_q);

        if (slot_q == SW'(REFRESH_DIV - 1)) begin
            slot_d = '0;
            k_d    = (k_q == KW'(NUM_DIGITS - 1)) ? '0 : k_q + KW'(1);
        end

        if (load) begin
            msg_d   = msg_data;
            state_d = (HOLD_STEPS == 0) ? SCROLL : HOLD;
            pos_d   = '0;
            div_d   = '0;
            hold_d  = '0;
        end else if (state_q != IDLE && !pause) begin
            if (div_q == DW'(SCROLL_DIV - 1)) begin
                div_d  = '0;
                step_d = 1'b1;
                if (state_q == HOLD) begin
                    if (hold_q == HW'(HOLD_STEPS - 1)) begin
                        state_d = SCROLL;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    pos_d = pos_next;
                    if (pos_next == '0) begin
                        state_d = (HOLD_STEPS == 0) ? SCROLL : HOLD;
                        hold_d  = '0;
                    end
                end
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            msg_q   <= '1;
            pos_q   <= '0;
            div_q   <= '0;
            hold_q  <= '0;
            slot_q  <= '0;
            k_q     <= '0;
            seg_q   <= SEG_BLANK;
            en_q    <= '1;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            pos_q   <= pos_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            slot_q  <= slot_d;
            k_q     <= k_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            step_q  <= step_d;
        end
    end

    assign seg        = seg_q;
    assign en         = en_q;
    assign scroll_pos = pos_q;
    assign step       = step_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Randomized scoreboard bench for scroll_display_ctrl against a behavioural model.
module tb_scroll_display_ctrl;

    localparam int N  = 4;
    localparam int L  = 6;
    localparam int SD = 4;
    localparam int R  = 2;
    localparam int HS = 2;
    localparam int MW = 4 * L;

    logic            clk = 1'b0;
    logic            reset, load, dir, pause;
    logic [MW-1:0]   msg_data;
    logic [6:0]      seg;
    logic [N-1:0]    en;
    logic [2:0]      scroll_pos;
    logic            step;

    int n_assert = 0;
    int n_fail   = 0;

    scroll_display_ctrl #(
        .NUM_DIGITS(N), .MSG_LEN(L), .SCROLL_DIV(SD), .REFRESH_DIV(R), .HOLD_STEPS(HS)
    ) dut (
        .clk(clk), .reset(reset), .msg_data(msg_data), .load(load), .dir(dir),
        .pause(pause), .seg(seg), .en(en), .scroll_pos(scroll_pos), .step(step)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int s);
        case (s)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h7F;
        endcase
    endfunction

    typedef struct {
        logic       step;
        int         pos;
        logic [6:0] seg;
        logic [N-1:0] en;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: message revolves under a window; after each load or
    // landing on 0 it dwells HS steps; steps come every SD unpaused cycles.
    int m_act, m_pos, m_cnt, m_dwell, m_slot, m_k;
    int m_msg[L];

    always @(posedge clk) begin
        exp_t e;
        if (!reset) begin
            m_act = 0; m_pos = 0; m_cnt = 0; m_dwell = 0; m_slot = 0; m_k = 0;
            for (int i = 0; i < L; i++) m_msg[i] = 15;
            e.seg = 7'h7F; e.en = '1; e.step = 1'b0; e.pos = 0;
        end else begin
            e.seg = m_act ? seg_of(m_msg[(m_pos + (N - 1 - m_k)) % L]) : 7'h7F;
            e.en  = ~(N'(1) << m_k);
            e.step = 1'b0;
            m_slot++;
            if (m_slot == R) begin m_slot = 0; m_k = (m_k + 1) % N; end
            if (load) begin
                for (int i = 0; i < L; i++) m_msg[i] = int'(msg_data[4*i +: 4]);
                m_act = 1; m_pos = 0; m_cnt = 0; m_dwell = HS;
            end else if (m_act != 0 && !pause) begin
                m_cnt++;
                if (m_cnt == SD) begin
                    m_cnt = 0;
                    e.step = 1'b1;
                    if (m_dwell > 0) m_dwell--;
                    else begin
                        m_pos = (m_pos + (dir ? L - 1 : 1)) % L;
                        if (m_pos == 0) m_dwell = HS;
                    end
                end
            end
            e.pos = m_pos;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (step !== e.step || int'(scroll_pos) != e.pos || seg !== e.seg || en !== e.en) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got step=%b pos=%0d seg=%h en=%h, want step=%b pos=%0d seg=%h en=%h",
                         $time, step, scroll_pos, seg, en, e.step, e.pos, e.seg, e.en);
            end
        end
    end

    task automatic wait_step_pos(input int p, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (step === 1'b1 && int'(scroll_pos) == p) found = 1;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_step_pos: no step onto pos %0d within %0d cycles (pos=%0d)", p, budget, scroll_pos);
        end
    endtask

    initial begin
        logic [6:0] got[N];
        logic [6:0] want[N];
        bit seen;
        reset = 1'b0; load = 1'b0; dir = 1'b0; pause = 1'b0; msg_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);

        #1 msg_data = MW'(24'h543210); load = 1'b1;
        @(posedge clk); #1 load = 1'b0;

        // Freeze at pos 4 and read one full scan: left->right 4,5,0,1.
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (int'(scroll_pos) == 4) seen = 1;
        end
        pause = 1'b1;
        repeat (2) @(negedge clk);
        for (int j = 0; j < N; j++) got[j] = 7'h7F;
        for (int i = 0; i < 2 * N * R; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) if (en[j] === 1'b0) got[j] = seg;
        end
        pause = 1'b0;
        want[3] = 7'h19; want[2] = 7'h12; want[1] = 7'h40; want[0] = 7'h79;
        for (int j = 0; j < N; j++) begin
            n_assert++;
            if (got[j] !== want[j]) begin
                n_fail++;
                $display("FAIL digit_at_pos4 en[%0d]: got seg=%h want %h", j, got[j], want[j]);
            end
        end

        // Reverse direction after revolving back to 0, with a mid-divider toggle.
        wait_step_pos(0, 200);
        dir = 1'b1;
        wait_step_pos(5, 100);
        wait_step_pos(4, 100);
        @(posedge clk); #1 dir = 1'b0;
        @(posedge clk); #1 dir = 1'b1;
        wait_step_pos(3, 100);
        @(posedge clk); #1 dir = 1'b0;

        @(posedge clk); #1 pause = 1'b1;
        repeat (20) @(posedge clk);
        #1 pause = 1'b0;

        // Load landing exactly on the step edge that would leave pos 3.
        wait_step_pos(3, 300);
        repeat (3) @(posedge clk);
        #1 msg_data = MW'(24'hABCDE9); load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        n_assert++;
        if (step !== 1'b0 || scroll_pos !== 3'd0) begin
            n_fail++;
            $display("FAIL load_vs_step: got step=%b pos=%0d want step=0 pos=0", step, scroll_pos);
        end

        wait_step_pos(2, 300);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 1500; i++) begin
            #1;
            load  = ($urandom_range(0, 99) < 2);
            if (load) msg_data = MW'($urandom());
            pause = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            reset = ($urandom_range(0, 399) != 0);
            @(posedge clk);
        end
        #1 reset = 1'b1; load = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
